// File: rtl/wf68k30l_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Function codes match the 68030 program-space encodings.
package wf68k30l_prefetch_queue_pkg;

  localparam logic [2:0] FC_USER_PROG  = 3'b010;
  localparam logic [2:0] FC_SUPER_PROG = 3'b110;
  localparam int         PQ_DEPTH_DEFAULT = 6;

  typedef enum logic [2:0] {
    IDLE_HALT,
    RUN,
    BUSY,
    FLUSH_WAIT,
    FAULTED
  } PQ_STATE_T;

  // A fetch that starts on the odd word of a longword only yields one usable word.
  function automatic logic [1:0] pq_fetch_words(input logic skip);
    return skip ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/wf68k30l_pq_ring.sv
// Circular word store with per-word fault tags; pushes 0-2 and pops 0-3 words per cycle.
// The three head positions are presented combinationally and read as zero past the fill level.
module wf68k30l_pq_ring #(
  parameter int DEPTH = 6,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic [1:0]    push_cnt,
  input  logic [15:0]   push_d0,
  input  logic [15:0]   push_d1,
  input  logic          push_fault,
  input  logic [1:0]    pop_cnt,
  output logic [CW-1:0] cnt,
  output logic [15:0]   word0,
  output logic [15:0]   word1,
  output logic [15:0]   word2,
  output logic [2:0]    fault
);

  localparam int IW = $clog2(DEPTH);

  logic [15:0]      mem [DEPTH];
  logic [DEPTH-1:0] fbit;
  logic [IW-1:0]    head, tail, idx1, idx2, tail1;
  logic [CW:0]      cnt_sum;

  function automatic logic [IW-1:0] adv(input logic [IW-1:0] p, input logic [1:0] n);
    logic [IW:0] s;
    s = {1'b0, p} + (IW+1)'(n);
    if (s >= (IW+1)'(DEPTH)) s = s - (IW+1)'(DEPTH);
    return s[IW-1:0];
  endfunction

  assign idx1    = adv(head, 2'd1);
  assign idx2    = adv(head, 2'd2);
  assign tail1   = adv(tail, 2'd1);
  assign cnt_sum = {1'b0, cnt} - (CW+1)'(pop_cnt) + (CW+1)'(push_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      fbit <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push_cnt != 2'd0) begin
        mem[tail]  <= push_d0;
        fbit[tail] <= push_fault;
      end
      if (push_cnt == 2'd2) begin
        mem[tail1]  <= push_d1;
        fbit[tail1] <= push_fault;
      end
      tail <= adv(tail, push_cnt);
      head <= adv(head, pop_cnt);
      cnt  <= cnt_sum[CW-1:0];
    end
  end

  assign word0 = (cnt > CW'(0)) ? mem[head] : 16'h0;
  assign word1 = (cnt > CW'(1)) ? mem[idx1] : 16'h0;
  assign word2 = (cnt > CW'(2)) ? mem[idx2] : 16'h0;
  assign fault = {(cnt > CW'(2)) && fbit[idx2],
                  (cnt > CW'(1)) && fbit[idx1],
                  (cnt > CW'(0)) && fbit[head]};

  // The issue rule reserves room before a fetch starts, so a push never overruns.
  assert property (@(posedge clk) disable iff (rst) !clear |-> (cnt_sum <= (CW+1)'(DEPTH)));
  assert property (@(posedge clk) disable iff (rst) !clear |-> ((CW+1)'(pop_cnt) <= {1'b0, cnt}));

endmodule

// File: rtl/wf68k30l_prefetch_queue.sv
// Instruction prefetch queue: fetches longwords on program function codes and feeds
// the decoder one op word plus two look-ahead words, carrying bus-error tags per word.
//
// state      | meaning
// IDLE_HALT  | after reset, no fetching until the first flush
// RUN        | may issue a fetch once the ring has room for it
// BUSY       | fetch outstanding, result goes into the ring
// FLUSH_WAIT | fetch outstanding across a flush, result is dropped
// FAULTED    | bus error seen, no fetching until a flush
module wf68k30l_prefetch_queue
  import wf68k30l_prefetch_queue_pkg::*;
#(
  parameter int DEPTH_WORDS = PQ_DEPTH_DEFAULT,
  parameter int ADR_W       = 32
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic                               FLUSH,
  input  logic [ADR_W-1:0]                   NEW_PC,
  input  logic                               SBIT,
  output logic                               FETCH_REQ,
  output logic [ADR_W-1:0]                   FETCH_ADR,
  output logic [2:0]                         FETCH_FC,
  input  logic                               FETCH_ACK,
  input  logic                               FETCH_BERR,
  input  logic [31:0]                        FETCH_DATA,
  output logic [$clog2(DEPTH_WORDS+1)-1:0]   WORD_CNT,
  output logic [15:0]                        OPWORD,
  output logic [15:0]                        EXT1,
  output logic [15:0]                        EXT2,
  output logic [2:0]                         FAULT,
  input  logic [1:0]                         CONSUME
);

  localparam int CW = $clog2(DEPTH_WORDS + 1);

  PQ_STATE_T        state, state_nxt;
  logic [ADR_W-1:0] fetch_ptr, fetch_ptr_nxt;
  logic             skip, skip_nxt;
  logic             req_q, req_nxt;
  logic [ADR_W-1:0] adr_q, adr_nxt;
  logic [2:0]       fc_q, fc_nxt;

  logic             ring_clear;
  logic [1:0]       push_cnt, pop_cnt, pop_eff, fetch_words;
  logic [15:0]      push_d0, push_d1;
  logic             push_fault;
  logic             room_ok;
  logic             unused_pc0;

  assign unused_pc0  = NEW_PC[0];
  assign fetch_words = pq_fetch_words(skip);

  always_comb begin
    pop_eff = CONSUME;
    if (CW'(CONSUME) > WORD_CNT) pop_eff = WORD_CNT[1:0];
  end

  // Room is judged against the fill level after this cycle's consumption.
  assign room_ok = ((CW+1)'(WORD_CNT) - (CW+1)'(pop_eff) + (CW+1)'(fetch_words))
                   <= (CW+1)'(DEPTH_WORDS);

  always_comb begin
    state_nxt     = state;
    fetch_ptr_nxt = fetch_ptr;
    skip_nxt      = skip;
    req_nxt       = req_q;
    adr_nxt       = adr_q;
    fc_nxt        = fc_q;
    ring_clear    = 1'b0;
    push_cnt      = 2'd0;
    push_d0       = 16'h0;
    push_d1       = 16'h0;
    push_fault    = 1'b0;
    pop_cnt       = pop_eff;

    if (FLUSH) begin
      ring_clear    = 1'b1;
      pop_cnt       = 2'd0;
      fetch_ptr_nxt = {NEW_PC[ADR_W-1:2], 2'b00};
      skip_nxt      = NEW_PC[1];
      if (req_q && !(FETCH_ACK || FETCH_BERR)) begin
        state_nxt = FLUSH_WAIT;
      end else begin
        state_nxt = RUN;
        req_nxt   = 1'b0;
      end
    end else begin
      case (state)
        IDLE_HALT, FAULTED: ;
        RUN: begin
          if (room_ok) begin
            req_nxt   = 1'b1;
            adr_nxt   = fetch_ptr;
            fc_nxt    = SBIT ? FC_SUPER_PROG : FC_USER_PROG;
            state_nxt = BUSY;
          end
        end
        BUSY: begin
          if (FETCH_ACK) begin
            push_cnt      = fetch_words;
            push_d0       = skip ? FETCH_DATA[15:0] : FETCH_DATA[31:16];
            push_d1       = FETCH_DATA[15:0];
            req_nxt       = 1'b0;
            skip_nxt      = 1'b0;
            fetch_ptr_nxt = fetch_ptr + ADR_W'(4);
            state_nxt     = RUN;
          end else if (FETCH_BERR) begin
            push_cnt   = fetch_words;
            push_fault = 1'b1;
            req_nxt    = 1'b0;
            state_nxt  = FAULTED;
          end
        end
        FLUSH_WAIT: begin
          if (FETCH_ACK || FETCH_BERR) begin
            req_nxt   = 1'b0;
            state_nxt = RUN;
          end
        end
        default: state_nxt = IDLE_HALT;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE_HALT;
      fetch_ptr <= '0;
      skip      <= 1'b0;
      req_q     <= 1'b0;
      adr_q     <= '0;
      fc_q      <= 3'b000;
    end else begin
      state     <= state_nxt;
      fetch_ptr <= fetch_ptr_nxt;
      skip      <= skip_nxt;
      req_q     <= req_nxt;
      adr_q     <= adr_nxt;
      fc_q      <= fc_nxt;
    end
  end

  assign FETCH_REQ = req_q;
  assign FETCH_ADR = adr_q;
  assign FETCH_FC  = fc_q;

  wf68k30l_pq_ring #(
    .DEPTH (DEPTH_WORDS),
    .CW    (CW)
  ) u_ring (
    .clk        (CLK),
    .rst        (RESET),
    .clear      (ring_clear),
    .push_cnt   (push_cnt),
    .push_d0    (push_d0),
    .push_d1    (push_d1),
    .push_fault (push_fault),
    .pop_cnt    (pop_cnt),
    .cnt        (WORD_CNT),
    .word0      (OPWORD),
    .word1      (EXT1),
    .word2      (EXT2),
    .fault      (FAULT)
  );

endmodule
